instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of the instruction memory. Owns the program counter and

---
 rtl/instr_fetch_unit_pkg.sv | 28 ++
 rtl/fetch_pc_reg.sv | 48 ++++
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch stage: default widths, the
// reset PC, the HALT opcode, the fetch FSM state encoding and an opcode helper.
// Optional feature macro used by the fetch stage: FETCH_HALT_EN.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    localparam int          ADDR_W_DEF   = 8;
    localparam int          INSTR_W_DEF  = 16;
    localparam int          OPC_W        = 4;
    localparam logic [7:0]  RESET_PC_DEF = 8'h00;
    localparam logic [3:0]  HALT_OPC_DEF = 4'hF;

    // Fetch FSM states; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_e;

    // True when the opcode field matches the configured HALT opcode.
    function automatic logic is_halt_opc(input logic [OPC_W-1:0] opc,
                                         input logic [OPC_W-1:0] halt_opc);
        return (opc == halt_opc);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
// Program counter register with its next-PC mux.
//   load_en / load_addr : redirect target, highest priority
//   inc_en              : advance PC by one (wraps at 2^ADDR_W)
//   otherwise           : hold
// Ports: clk, rst (async, active-high), load_en, load_addr, inc_en, pc_q.
// -----------------------------------------------------------------------------
module fetch_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc_q
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_d;

    // Next-PC selection: redirect beats increment beats hold.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_addr;
        end else if (inc_en) begin
            pc_d = pc_q + PC_ONE;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register, asynchronously reset to RESET_PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage in front of a combinational instruction memory. Owns the PC
// (via fetch_pc_reg), captures the returned instruction into an instruction
// register with its fetch PC and a valid flag, and handles stall and redirect.
// Optional HALT detection is compiled in when FETCH_HALT_EN is defined.
// Ports:
//   clk, rst (async, active-high)
//   stall                          hold PC and IR
//   redirect_valid, redirect_addr  branch/jump target, flushes the IR
//   instr_in                       memory data for pc_addr
//   pc_addr                        PC register output
//   ir_out, ir_pc, ir_valid        registered instruction, its PC, live flag
//   halted                         fetch stopped on HALT (0 without FETCH_HALT_EN)
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
`ifdef FETCH_HALT_EN
    ,
    parameter logic [OPC_W-1:0]  HALT_OPC = HALT_OPC_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [ADDR_W-1:0]  pc_addr,
    output logic [INSTR_W-1:0] ir_out,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] ir_out_q, ir_out_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               halted_q, halted_d;
    logic               pc_load_s;
    logic               pc_inc_s;
    logic [ADDR_W-1:0]  pc_s;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load_en   (pc_load_s),
        .load_addr (redirect_addr),
        .inc_en    (pc_inc_s),
        .pc_q      (pc_s)
    );

    // Fetch FSM next-state, IR capture and PC control.
    always_comb begin
        state_d    = state_q;
        ir_out_d   = ir_out_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        pc_load_s  = 1'b0;
        pc_inc_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // One dead edge after reset so the memory sees RESET_PC first.
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_load_s  = 1'b1;
                    ir_valid_d = 1'b0;
                end else if (stall) begin
                    ir_valid_d = ir_valid_q;
                end else begin
                    ir_out_d   = instr_in;
                    ir_pc_d    = pc_s;
                    ir_valid_d = 1'b1;
`ifdef FETCH_HALT_EN
                    if (is_halt_opc(instr_in[INSTR_W-1 -: OPC_W], HALT_OPC)) begin
                        // Keep the HALT instruction visible for one cycle; PC stays on it.
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_inc_s = 1'b1;
                    end
`else
                    pc_inc_s   = 1'b1;
`endif
                end
            end

            ST_HALTED: begin
`ifdef FETCH_HALT_EN
                if (redirect_valid) begin
                    pc_load_s  = 1'b1;
                    halted_d   = 1'b0;
                    ir_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end else if (!stall) begin
                    // The HALT instruction retires once downstream takes it.
                    ir_valid_d = 1'b0;
                end else begin
                    ir_valid_d = ir_valid_q;
                end
`else
                state_d = ST_IDLE;
`endif
            end

            default: begin
                state_d    = ST_IDLE;
                ir_valid_d = 1'b0;
                halted_d   = 1'b0;
            end
        endcase
    end

    // FSM state and instruction register, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ir_out_q   <= {INSTR_W{1'b0}};
            ir_pc_q    <= {ADDR_W{1'b0}};
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_out_q   <= ir_out_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign pc_addr  = pc_s;
    assign ir_out   = ir_out_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit with a combinational memory model.
// Each scenario task pushes the expected post-edge outputs into a scoreboard
// queue when it drives stimulus, then pops and compares after the edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] ir;
        logic [7:0]  irpc;
        logic        v;
        logic        h;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic [15:0] instr_in;
    logic [7:0]  pc_addr;
    logic [15:0] ir_out;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        halted;

    logic [15:0] mem [256];
    obs_t        sb [$];
    int          compared;
    int          mismatched;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_in       (instr_in),
        .pc_addr        (pc_addr),
        .ir_out         (ir_out),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .halted         (halted)
    );

    assign instr_in = mem[pc_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(input logic [7:0] pc, input logic [15:0] ir,
                                input logic [7:0] irpc, input logic v, input logic h);
        obs_t o;
        o.pc = pc; o.ir = ir; o.irpc = irpc; o.v = v; o.h = h;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(pc_addr, ir_out, ir_pc, ir_valid, halted);
    endfunction

    // Apply inputs for one cycle, then sample 1 time unit after the edge.
    task automatic cycle(input logic s, input logic r, input logic [7:0] a);
        stall          = s;
        redirect_valid = r;
        redirect_addr  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
        sb.push_back(mk(8'h00, 16'h0000, 8'h00, 1'b0, 1'b0));
        #2;
        e = sb.pop_front(); g = sample(); compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL reset: got %h want %h", g, e);
        end
    endtask

    task automatic test_basic();
        obs_t e, g;
        rst = 1'b0;
        // Edge 1 leaves IDLE, then one instruction per edge.
        for (int i = 0; i < 6; i++) begin
            if (i == 0) sb.push_back(mk(8'h00, 16'h0000, 8'h00, 1'b0, 1'b0));
            else        sb.push_back(mk(8'(i), mem[i-1], 8'(i-1), 1'b1, 1'b0));
            cycle(1'b0, 1'b0, 8'h00);
            e = sb.pop_front(); g = sample(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL basic[%0d]: got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_stall();
        obs_t e, g;
        // PC is 5 here with mem[4] in the IR.
        for (int i = 0; i < 3; i++) begin
            if (i < 2) sb.push_back(mk(8'h05, mem[4], 8'h04, 1'b1, 1'b0));
            else       sb.push_back(mk(8'h06, mem[5], 8'h05, 1'b1, 1'b0));
            cycle((i < 2) ? 1'b1 : 1'b0, 1'b0, 8'h00);
            e = sb.pop_front(); g = sample(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL stall[%0d]: got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_redirect();
        obs_t e, g;
        // Redirect with stall: redirect wins, IR flushed but data held.
        sb.push_back(mk(8'h54, mem[5], 8'h05, 1'b0, 1'b0));
        cycle(1'b1, 1'b1, 8'h54);
        e = sb.pop_front(); g = sample(); compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL redirect_flush: got %h want %h", g, e);
        end
        sb.push_back(mk(8'h55, mem[8'h54], 8'h54, 1'b1, 1'b0));
        cycle(1'b0, 1'b0, 8'h00);
        e = sb.pop_front(); g = sample(); compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL redirect_target: got %h want %h", g, e);
        end
    endtask

    task automatic test_wrap();
        obs_t e, g;
        logic [7:0] exp_pc [3];
        exp_pc[0] = 8'hFF; exp_pc[1] = 8'h00; exp_pc[2] = 8'h01;
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      sb.push_back(mk(exp_pc[0], mem[8'h54], 8'h54, 1'b0, 1'b0));
            else if (i == 1) sb.push_back(mk(exp_pc[1], mem[8'hFF], 8'hFF, 1'b1, 1'b0));
            else             sb.push_back(mk(exp_pc[2], mem[8'h00], 8'h00, 1'b1, 1'b0));
            cycle(1'b0, (i == 0) ? 1'b1 : 1'b0, 8'hFF);
            e = sb.pop_front(); g = sample(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL wrap[%0d]: got %h want %h", i, g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        // Two redirects in a row, then fetch from the second target.
        sb.push_back(mk(8'h10, mem[8'h00], 8'h00, 1'b0, 1'b0));
        cycle(1'b0, 1'b1, 8'h10);
        e = sb.pop_front(); g = sample(); compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL b2b_first: got %h want %h", g, e);
        end
        sb.push_back(mk(8'h20, mem[8'h00], 8'h00, 1'b0, 1'b0));
        cycle(1'b0, 1'b1, 8'h20);
        e = sb.pop_front(); g = sample(); compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL b2b_second: got %h want %h", g, e);
        end
        sb.push_back(mk(8'h21, mem[8'h20], 8'h20, 1'b1, 1'b0));
        cycle(1'b0, 1'b0, 8'h00);
        e = sb.pop_front(); g = sample(); compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL b2b_fetch: got %h want %h", g, e);
        end
    endtask

    task automatic test_halt();
        obs_t e, g;
        sb.push_back(mk(8'h2A, mem[8'h20], 8'h20, 1'b0, 1'b0));
        cycle(1'b0, 1'b1, 8'h2A);
        e = sb.pop_front(); g = sample(); compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL halt_redirect: got %h want %h", g, e);
        end
`ifdef FETCH_HALT_EN
        sb.push_back(mk(8'h2A, 16'hF000, 8'h2A, 1'b1, 1'b1));
        sb.push_back(mk(8'h2A, 16'hF000, 8'h2A, 1'b0, 1'b1));
        sb.push_back(mk(8'h2A, 16'hF000, 8'h2A, 1'b0, 1'b1));
        sb.push_back(mk(8'h22, 16'hF000, 8'h2A, 1'b0, 1'b0));
        sb.push_back(mk(8'h23, mem[8'h22], 8'h22, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) begin
            cycle((i == 2) ? 1'b1 : 1'b0, (i == 3) ? 1'b1 : 1'b0, 8'h22);
            e = sb.pop_front(); g = sample(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL halt[%0d]: got %h want %h", i, g, e);
            end
        end
`else
        // Without halt support the F-opcode is an ordinary instruction.
        sb.push_back(mk(8'h2B, 16'hF000, 8'h2A, 1'b1, 1'b0));
        sb.push_back(mk(8'h2C, mem[8'h2B], 8'h2B, 1'b1, 1'b0));
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            e = sb.pop_front(); g = sample(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL nohalt[%0d]: got %h want %h", i, g, e);
            end
        end
`endif
    endtask

    task automatic test_async_reset();
        obs_t e, g;
        // Assert reset between edges; outputs must clear with no clock edge.
        #3;
        rst = 1'b1;
        sb.push_back(mk(8'h00, 16'h0000, 8'h00, 1'b0, 1'b0));
        #1;
        e = sb.pop_front(); g = sample(); compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL async_reset: got %h want %h", g, e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back(mk(8'h00, 16'h0000, 8'h00, 1'b0, 1'b0));
        sb.push_back(mk(8'h01, mem[8'h00], 8'h00, 1'b1, 1'b0));
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            e = sb.pop_front(); g = sample(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL post_reset[%0d]: got %h want %h", i, g, e);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {i[7:0], ~i[7:0]};
        end
        mem[0]     = 16'h1111;
        mem[1]     = 16'h2222;
        mem[2]     = 16'h3333;
        mem[8'h2A] = 16'hF000;

        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_halt();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
